gather_sched: RTL
=================

GATHER_SCHED -- requirements
Module: gather_sched

Interface
REQ-001 SHALL have parameter DATA, 32, data width per entry.
REQ-002 SHALL have parameter IN, 8, number of entries in an input bundle.
REQ-003 SHALL have parameter OUT, 4, maximum entries issued per output beat (1 <= OUT <= IN).
REQ-004 SHALL have parameter ACT, `HIGH, polarity of sel and out_valid; all other handshakes are active-high.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port reset_  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  input bundle present.
REQ-008 SHALL have port in_ready  output  1  bundle accepted when in_valid && in_ready.
REQ-009 SHALL have port in  input  [IN-1:0][DATA-1:0]  bundle data.
REQ-010 SHALL have port sel  input  [IN-1:0]  per-entry enable, polarity ACT.
REQ-011 SHALL have port out_valid  output  [OUT-1:0]  per-lane valid, polarity ACT.
REQ-012 SHALL have port out  output  [OUT-1:0][DATA-1:0]  compacted beat data.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the whole beat.
REQ-014 SHALL have port remain  output  [$clog2(IN+1)-1:0]  count of pending entries.
REQ-015 SHALL have port beat  output  [$clog2(IN+1)-1:0]  beats issued from current bundle.

Function
REQ-016 SHALL implement FSM with states IDLE and DRAIN.
REQ-017 SHALL in IDLE drive in_ready=1, out_valid all DISABLE, out all zero.
REQ-018 SHALL on accept register in and sel into bundle/pending registers, clear beat, go DRAIN if any sel entry is ENABLE.
REQ-019 SHALL on accept with no sel entry ENABLE discard the bundle and stay IDLE.
REQ-020 SHALL in DRAIN present pending entries compacted in ascending index order: lane k = k-th lowest pending entry; lanes beyond pending count DISABLE with data zero.
REQ-021 SHALL present the first beat in the cycle after accept (latency 1); no combinational in-to-out path.
REQ-022 SHALL define fire = DRAIN && out_ready; out/out_valid stay stable while out_ready is low.
REQ-023 SHALL on fire clear the pending bits of all issued entries, decrement remain by issued count, increment beat.
REQ-024 SHALL on fire with remain <= OUT (last beat) return to IDLE.
REQ-025 SHALL assert in_ready in DRAIN only on the last beat with out_ready high; a simultaneous accept loads the new bundle and stays in DRAIN (or goes IDLE if the new sel is empty), giving back-to-back bundles with no bubble.
REQ-026 SHALL ignore in_valid while in_ready is low; in/sel not sampled.
REQ-027 SHALL compute remain as popcount of pending bits (0 in IDLE); beat saturates at IN.
REQ-028 SHALL issue ceil(N/OUT) beats for a bundle with N enabled entries, every enabled entry exactly once.

Reset
REQ-029 SHALL on reset_ low, immediately and regardless of state: go IDLE, clear pending, remain=0, beat=0, out_valid all DISABLE, out zero, in_ready=1 after release.
REQ-030 SHALL discard a partially drained bundle on reset mid-DRAIN; no further beats from it.

Verification
REQ-031 SHALL cover IN=8 OUT=4 ACT=HIGH, sel=8'b1010_0110 -> one beat next cycle, lanes in[1],in[2],in[5],in[7], out_valid=4'b1111, then IDLE.
REQ-032 SHALL cover sel=8'hFF with out_ready low 3 cycles -> beat 0 held stable (in[0..3]), then in[4..7], remain 8->4->0, beat 0->1->2.
REQ-033 SHALL cover sel=8'b0000_0100 -> out_valid=4'b0001 out[0]=in[2], other lanes zero; sel=8'h00 -> stays IDLE, no beat.
REQ-034 SHALL cover back-to-back: bundle A sel=8'hFF, bundle B held valid -> B accepted on A's last fire, B's first beat the next cycle, no idle cycle.
REQ-035 SHALL cover reset_ asserted mid-DRAIN after first beat of sel=8'hFF -> out_valid 0, remain 0 asynchronously, in_ready=1 after release, no stale beat.
REQ-036 SHALL cover ACT=LOW, sel=8'b1111_1100 (entries 0,1 enabled) -> out_valid=4'b1100, out[0]=in[0], out[1]=in[1].

Source files
------------

// File: rtl/gather_sched.sv
// gather_sched -- gathers the selected entries of an input bundle and issues
// them, compacted in ascending index order, as beats of up to OUT entries.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset_     asynchronous active-low reset
//   in_valid   input bundle present
//   in_ready   bundle accepted when in_valid && in_ready
//   in         bundle data, IN entries of DATA bits
//   sel        per-entry enable, polarity ACT
//   out_valid  per-lane valid, polarity ACT
//   out        compacted beat data, OUT lanes of DATA bits
//   out_ready  consumer accepts the whole beat
//   remain     number of entries still pending
//   beat       beats issued from the current bundle (saturates at IN)
//
// ACT = 1'b1 selects active-high sel/out_valid, 1'b0 active-low.
module gather_sched #(
  parameter int DATA = 32,
  parameter int IN   = 8,
  parameter int OUT  = 4,
  parameter bit ACT  = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset_,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN-1:0][DATA-1:0]            in,
  input  logic [IN-1:0]                      sel,
  output logic [OUT-1:0]                     out_valid,
  output logic [OUT-1:0][DATA-1:0]           out,
  input  logic                               out_ready,
  output logic [$clog2(IN+1)-1:0]            remain,
  output logic [$clog2(IN+1)-1:0]            beat
);

  localparam int CW = $clog2(IN+1);
  localparam logic [CW-1:0] OUT_C = CW'(OUT);
  localparam logic [CW-1:0] IN_C  = CW'(IN);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [OUT-1:0] DIS_C = ACT ? {OUT{1'b0}} : {OUT{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef logic [IN-1:0][CW-1:0] pos_t;

  // Number of set bits in a pending vector.
  function automatic logic [CW-1:0] popcount(input logic [IN-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < IN; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  // For each entry, the count of set bits strictly below it: its lane number
  // if it is pending.
  function automatic pos_t prefix_pos(input logic [IN-1:0] v);
    pos_t          pos;
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < IN; i++) begin
      pos[i] = cnt;
      cnt    = cnt + CW'(v[i]);
    end
    return pos;
  endfunction

  state_t                    r_state;
  logic [IN-1:0]             r_pend;
  logic [IN-1:0][DATA-1:0]   r_data;
  logic [CW-1:0]             r_remain;
  logic [CW-1:0]             r_beat;
  logic [OUT-1:0][DATA-1:0]  r_out;
  logic [OUT-1:0]            r_out_valid;

  logic [IN-1:0]             w_sel_en;
  logic                      w_fire;
  logic                      w_last;
  logic                      w_accept;
  pos_t                      w_pos_cur;
  pos_t                      w_pos_nxt;
  logic [IN-1:0]             w_issued;
  logic [IN-1:0]             w_pend_nxt;
  logic [IN-1:0][DATA-1:0]   w_data_nxt;
  logic [OUT-1:0][DATA-1:0]  w_lane;
  logic [OUT-1:0]            w_lane_v;

  // sel normalised to active-high internally.
  assign w_sel_en = sel ^ {IN{~ACT}};

  assign w_fire   = (r_state == DRAIN) && out_ready;
  assign w_last   = (r_state == DRAIN) && (r_remain <= OUT_C);
  // A new bundle may only enter when the current one leaves on this edge.
  assign in_ready = (r_state == IDLE) || (w_fire && w_last);
  assign w_accept = in_valid && in_ready;

  assign w_pos_cur = prefix_pos(r_pend);
  assign w_pos_nxt = prefix_pos(w_pend_nxt);

  // Entries presented on the current beat: the first OUT pending ones.
  always_comb begin
    w_issued = '0;
    for (int i = 0; i < IN; i++) begin
      w_issued[i] = r_pend[i] && (w_pos_cur[i] < OUT_C);
    end
  end

  // Pending set and bundle data after this edge.
  always_comb begin
    w_pend_nxt = r_pend;
    w_data_nxt = r_data;
    if (w_accept) begin
      w_pend_nxt = w_sel_en;
      w_data_nxt = in;
    end else if (w_fire) begin
      w_pend_nxt = r_pend & ~w_issued;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // Compact the next pending set into lanes so the outputs can be registered;
  // at most one entry matches each lane, so OR-ing is a clean mux.
  always_comb begin
    w_lane   = '0;
    w_lane_v = '0;
    for (int k = 0; k < OUT; k++) begin
      for (int i = 0; i < IN; i++) begin
        w_lane[k]   = w_lane[k] |
                      (w_data_nxt[i] & {DATA{w_pend_nxt[i] && (w_pos_nxt[i] == CW'(k))}});
        w_lane_v[k] = w_lane_v[k] | (w_pend_nxt[i] && (w_pos_nxt[i] == CW'(k)));
      end
    end
  end

  // Scheduler FSM with bundle storage and registered outputs.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_data      <= '0;
      r_remain    <= '0;
      r_beat      <= '0;
      r_out       <= '0;
      r_out_valid <= DIS_C;
    end else begin
      r_pend      <= w_pend_nxt;
      r_data      <= w_data_nxt;
      r_remain    <= popcount(w_pend_nxt);
      r_out       <= w_lane;
      r_out_valid <= ACT ? w_lane_v : ~w_lane_v;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_beat  <= '0;
            r_state <= (|w_sel_en) ? DRAIN : IDLE;
          end else begin
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (w_accept) begin
            // Last beat leaves while the next bundle loads: no bubble.
            r_beat  <= '0;
            r_state <= (|w_sel_en) ? DRAIN : IDLE;
          end else if (w_fire) begin
            r_beat  <= (r_beat == IN_C) ? r_beat : r_beat + ONE_C;
            r_state <= w_last ? IDLE : DRAIN;
          end else begin
            r_state <= DRAIN;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign remain    = r_remain;
  assign beat      = r_beat;

endmodule
